im_fetch_ctrl: RTL and testbench

IM_FETCH_CTRL -- requirements
Module: im_fetch_ctrl

---
 rtl/im_fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_im_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// im_fetch_ctrl
//
// Purpose:
//   Front-end controller for a dual-issue instruction memory. It has three
//   modes: LOAD (a boot-loader streams words into the instruction memory
//   through its write port), RUN (a PC drives two consecutive read slots and
//   advances by however many instructions the back-end consumed), and HALT
//   (everything frozen until reset or a reload request).
//
// Handshake:
//   There is no valid/ready pair on this block. The back-end reports
//   consumption through issue_cnt, and stall holds the PC. fetch_vld tells the
//   back-end whether the slot pair on im_addr0/im_addr1 is meaningful in the
//   current cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_we, ld_wdata, ld_done boot-loader word stream and end-of-load pulse
//   ld_req                   reload request, honoured from RUN or HALT
//   stall, issue_cnt         back-end hold and consumed-instruction count
//   redirect, redirect_addr  taken branch/jump and its word target
//   halt                     HLT retired
//   im_addr0, im_addr1       read addresses for slot 0 and slot 1
//   im_we, im_waddr, im_wdata instruction memory write port (LOAD only)
//   fetch_vld                slot pair valid this cycle
//   state_o                  current state (0 LOAD, 1 RUN, 2 HALT)
//   fetch_cnt                saturating count of consumed instructions
// ---------------------------------------------------------------------------
module im_fetch_ctrl #(
    parameter int IM_AW = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_we,
    input  logic [31:0]      ld_wdata,
    input  logic             ld_done,
    input  logic             ld_req,
    input  logic             stall,
    input  logic [1:0]       issue_cnt,
    input  logic             redirect,
    input  logic [IM_AW-1:0] redirect_addr,
    input  logic             halt,
    output logic [IM_AW-1:0] im_addr0,
    output logic [IM_AW-1:0] im_addr1,
    output logic             im_we,
    output logic [IM_AW-1:0] im_waddr,
    output logic [31:0]      im_wdata,
    output logic             fetch_vld,
    output logic [1:0]       state_o,
    output logic [31:0]      fetch_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           r_state;
    logic [IM_AW-1:0] r_pc;
    logic [IM_AW-1:0] r_lptr;
    logic [31:0]      r_cnt;
    logic             r_bubble;

    logic [1:0]       w_issue;
    logic [IM_AW-1:0] w_issue_ext;
    logic [IM_AW-1:0] w_pc_p1;
    logic [IM_AW-1:0] w_lptr_p1;
    logic [32:0]      w_cnt_sum;
    logic [31:0]      w_cnt_next;

    // issue_cnt of 3 is not a legal encoding; clamp it to the dual-issue max.
    assign w_issue     = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    assign w_issue_ext = {{(IM_AW-2){1'b0}}, w_issue};
    assign w_pc_p1     = r_pc + {{(IM_AW-1){1'b0}}, 1'b1};
    assign w_lptr_p1   = r_lptr + {{(IM_AW-1){1'b0}}, 1'b1};

    // Saturating add: a carry out of bit 31 pins the counter at all-ones.
    assign w_cnt_sum  = {1'b0, r_cnt} + {31'b0, w_issue};
    assign w_cnt_next = w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_LOAD;
            r_pc     <= '0;
            r_lptr   <= '0;
            r_cnt    <= '0;
            r_bubble <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_bubble <= 1'b0;
                    if (ld_done) begin
                        // A word written alongside ld_done still lands at
                        // r_lptr; the pointer itself restarts for next load.
                        r_state <= ST_RUN;
                        r_pc    <= '0;
                        r_lptr  <= '0;
                        r_cnt   <= '0;
                    end else if (ld_we) begin
                        r_lptr <= w_lptr_p1;
                    end
                end
                ST_RUN: begin
                    if (ld_req) begin
                        r_state  <= ST_LOAD;
                        r_lptr   <= '0;
                        r_bubble <= 1'b0;
                    end else if (halt) begin
                        r_state  <= ST_HALT;
                        r_bubble <= 1'b0;
                    end else if (redirect) begin
                        // The read memory samples on the negedge, so the
                        // first cycle at the new target is not yet valid.
                        r_pc     <= redirect_addr;
                        r_bubble <= 1'b1;
                        if (!stall) begin
                            r_cnt <= w_cnt_next;
                        end
                    end else if (stall) begin
                        r_bubble <= 1'b0;
                    end else begin
                        r_pc     <= r_pc + w_issue_ext;
                        r_cnt    <= w_cnt_next;
                        r_bubble <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_bubble <= 1'b0;
                    if (ld_req) begin
                        r_state <= ST_LOAD;
                        r_lptr  <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_LOAD;
                    r_lptr   <= '0;
                    r_bubble <= 1'b0;
                end
            endcase
        end
    end

    assign im_addr0  = r_pc;
    assign im_addr1  = w_pc_p1;
    assign im_we     = (r_state == ST_LOAD) && ld_we;
    assign im_waddr  = r_lptr;
    assign im_wdata  = ld_wdata;
    assign fetch_vld = (r_state == ST_RUN) && !r_bubble;
    assign state_o   = r_state;
    assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_im_fetch_ctrl
//
// Purpose:
//   Directed, table-driven bench for im_fetch_ctrl. Each table row holds the
//   inputs for one clock cycle and the outputs expected during that cycle
//   (before the rising edge that consumes the inputs). A hand-written
//   sequence afterwards walks the load pointer through its full wrap.
// ---------------------------------------------------------------------------
module tb_im_fetch_ctrl;

    localparam int IM_AW = 14;

    logic             clk;
    logic             rst;
    logic             ld_we;
    logic [31:0]      ld_wdata;
    logic             ld_done;
    logic             ld_req;
    logic             stall;
    logic [1:0]       issue_cnt;
    logic             redirect;
    logic [IM_AW-1:0] redirect_addr;
    logic             halt;
    logic [IM_AW-1:0] im_addr0;
    logic [IM_AW-1:0] im_addr1;
    logic             im_we;
    logic [IM_AW-1:0] im_waddr;
    logic [31:0]      im_wdata;
    logic             fetch_vld;
    logic [1:0]       state_o;
    logic [31:0]      fetch_cnt;

    im_fetch_ctrl #(.IM_AW(IM_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_we         (ld_we),
        .ld_wdata      (ld_wdata),
        .ld_done       (ld_done),
        .ld_req        (ld_req),
        .stall         (stall),
        .issue_cnt     (issue_cnt),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .im_addr0      (im_addr0),
        .im_addr1      (im_addr1),
        .im_we         (im_we),
        .im_waddr      (im_waddr),
        .im_wdata      (im_wdata),
        .fetch_vld     (fetch_vld),
        .state_o       (state_o),
        .fetch_cnt     (fetch_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] wd;
        logic        done;
        logic        req;
        logic        stall;
        logic [1:0]  iss;
        logic        rd;
        logic [13:0] ra;
        logic        hlt;
        logic [1:0]  e_st;
        logic [13:0] e_a0;
        logic [13:0] e_a1;
        logic        e_vld;
        logic [31:0] e_cnt;
        logic        e_we;
        logic [13:0] e_wa;
    } vec_t;

    vec_t vecs[$];

    int checks;
    int failures;

    task automatic add(input logic r, input logic we, input logic [31:0] wd,
                       input logic done, input logic req, input logic stl,
                       input logic [1:0] iss, input logic rd,
                       input logic [13:0] ra, input logic hlt,
                       input logic [1:0] e_st, input logic [13:0] e_a0,
                       input logic [13:0] e_a1, input logic e_vld,
                       input logic [31:0] e_cnt, input logic e_we,
                       input logic [13:0] e_wa);
        vec_t v;
        v.rst = r;  v.we = we;  v.wd = wd;  v.done = done; v.req = req;
        v.stall = stl; v.iss = iss; v.rd = rd; v.ra = ra; v.hlt = hlt;
        v.e_st = e_st; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_vld = e_vld;
        v.e_cnt = e_cnt; v.e_we = e_we; v.e_wa = e_wa;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; ld_we = 1'b0; ld_wdata = '0; ld_done = 1'b0;
        ld_req = 1'b0; stall = 1'b0; issue_cnt = 2'd0; redirect = 1'b0;
        redirect_addr = '0; halt = 1'b0;
    endtask

    task automatic apply_and_check(input int idx, input vec_t v);
        @(negedge clk);
        rst = v.rst; ld_we = v.we; ld_wdata = v.wd; ld_done = v.done;
        ld_req = v.req; stall = v.stall; issue_cnt = v.iss;
        redirect = v.rd; redirect_addr = v.ra; halt = v.hlt;
        #2;
        check("state",     idx, {30'b0, state_o},   {30'b0, v.e_st});
        check("im_addr0",  idx, {18'b0, im_addr0},  {18'b0, v.e_a0});
        check("im_addr1",  idx, {18'b0, im_addr1},  {18'b0, v.e_a1});
        check("fetch_vld", idx, {31'b0, fetch_vld}, {31'b0, v.e_vld});
        check("fetch_cnt", idx, fetch_cnt,          v.e_cnt);
        check("im_we",     idx, {31'b0, im_we},     {31'b0, v.e_we});
        check("im_waddr",  idx, {18'b0, im_waddr},  {18'b0, v.e_wa});
        if (v.e_we) check("im_wdata", idx, im_wdata, v.wd);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive_idle();

        //   rst we wd         dn rq st is rd ra       hl | st a0       a1       vld cnt we wa
        // Load three words, then ld_done.
        add(0, 1, 32'hA,      0, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 1, 14'h0);
        add(0, 1, 32'hB,      0, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 1, 14'h1);
        add(0, 1, 32'hC,      0, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 1, 14'h2);
        add(0, 0, 32'h0,      1, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 0, 14'h3);
        // Sequential advance 2,2,1,0.
        add(0, 0, 32'h0,      0, 0, 0, 2, 0, 14'h0,    0,  1, 14'h0,    14'h1,    1,  0, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 2, 0, 14'h0,    0,  1, 14'h2,    14'h3,    1,  2, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 1, 0, 14'h0,    0,  1, 14'h4,    14'h5,    1,  4, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 0, 0, 14'h0,    0,  1, 14'h5,    14'h6,    1,  5, 0, 14'h0);
        // Stall with illegal issue_cnt=3 holds; then 3 advances as 2.
        add(0, 0, 32'h0,      0, 0, 1, 3, 0, 14'h0,    0,  1, 14'h5,    14'h6,    1,  5, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 3, 0, 14'h0,    0,  1, 14'h5,    14'h6,    1,  5, 0, 14'h0);
        // Redirect under stall: PC jumps, count frozen, one-cycle bubble.
        add(0, 0, 32'h0,      0, 0, 1, 2, 1, 14'h100,  0,  1, 14'h7,    14'h8,    1,  7, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 0, 0, 14'h0,    0,  1, 14'h100,  14'h101,  0,  7, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 0, 0, 14'h0,    0,  1, 14'h100,  14'h101,  1,  7, 0, 14'h0);
        // Redirect without stall still counts; PC at top wraps slot 1.
        add(0, 0, 32'h0,      0, 0, 0, 1, 1, 14'h3FFF, 0,  1, 14'h100,  14'h101,  1,  7, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 0, 0, 14'h0,    0,  1, 14'h3FFF, 14'h0,    0,  8, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 2, 0, 14'h0,    0,  1, 14'h3FFF, 14'h0,    1,  8, 0, 14'h0);
        // halt beats redirect; HALT ignores everything but ld_req.
        add(0, 0, 32'h0,      0, 0, 0, 2, 1, 14'h200,  1,  1, 14'h1,    14'h2,    1, 10, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 2, 1, 14'h55,   0,  2, 14'h1,    14'h2,    0, 10, 0, 14'h0);
        add(0, 0, 32'h0,      0, 1, 0, 0, 0, 14'h0,    0,  2, 14'h1,    14'h2,    0, 10, 0, 14'h0);
        // Reload from address 0; RUN-side inputs ignored in LOAD.
        add(0, 1, 32'hDEAD,   0, 0, 0, 0, 0, 14'h0,    0,  0, 14'h1,    14'h2,    0, 10, 1, 14'h0);
        add(0, 1, 32'hBEEF,   0, 0, 1, 2, 1, 14'h40,   1,  0, 14'h1,    14'h2,    0, 10, 1, 14'h1);
        // rst with ld_done after two words: stay in LOAD, pointer back to 0.
        add(1, 1, 32'h1234,   1, 0, 0, 0, 0, 14'h0,    0,  0, 14'h1,    14'h2,    0, 10, 1, 14'h2);
        add(0, 1, 32'h77,     0, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 1, 14'h0);
        // Word written together with ld_done still goes to the pointer.
        add(0, 1, 32'h88,     1, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 1, 14'h1);
        // ld_req beats issue in RUN: no count, back to LOAD.
        add(0, 0, 32'h0,      0, 1, 0, 2, 0, 14'h0,    0,  1, 14'h0,    14'h1,    1,  0, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 0, 14'h0);
        add(0, 0, 32'h0,      1, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 0, 14'h0);
        // rst overrides redirect in RUN.
        add(1, 0, 32'h0,      0, 0, 0, 2, 1, 14'h10,   0,  1, 14'h0,    14'h1,    1,  0, 0, 14'h0);
        add(0, 0, 32'h0,      0, 0, 0, 0, 0, 14'h0,    0,  0, 14'h0,    14'h1,    0,  0, 0, 14'h0);

        // Initial reset, then check reset state before the table runs.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_state", -1, {30'b0, state_o},   32'd0);
        check("rst_addr0", -1, {18'b0, im_addr0},  32'd0);
        check("rst_addr1", -1, {18'b0, im_addr1},  32'd1);
        check("rst_vld",   -1, {31'b0, fetch_vld}, 32'd0);
        check("rst_cnt",   -1, fetch_cnt,          32'd0);
        check("rst_waddr", -1, {18'b0, im_waddr},  32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_and_check(i, vecs[i]);
        end

        // Load pointer wrap: 2^14 writes return the pointer to 0, and the
        // write after that lands at 1.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ld_we = 1'b1;
        for (int n = 0; n < (1 << IM_AW); n++) begin
            ld_wdata = n;
            if (n == (1 << IM_AW) - 1) begin
                #2;
                check("wrap_last_waddr", n, {18'b0, im_waddr}, 32'h3FFF);
            end
            @(negedge clk);
        end
        ld_wdata = 32'hCAFE;
        #2;
        check("wrap_waddr0", -2, {18'b0, im_waddr}, 32'd0);
        check("wrap_we",     -2, {31'b0, im_we},    32'd1);
        check("wrap_wdata",  -2, im_wdata,          32'hCAFE);
        @(negedge clk);
        #2;
        check("wrap_waddr1", -2, {18'b0, im_waddr}, 32'd1);
        drive_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
